// File: rtl/dma_regfile.sv
// Shared DMA definitions: scheduler state encoding, AXI burst encoding and
// the AXI 4 KB page size that INCR bursts must not cross.
package dma_regfile;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_RD_CMD  = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_WR_CMD  = 3'd4,
      ST_WR_WAIT = 3'd5
   } dma_sched_state_t;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_ERR   = 2'b11
   } dma_burst_t;

   localparam logic [31:0] BOUNDARY_4KB = 32'd4096;

endpackage

// File: rtl/dma_chunk_calc.sv
// Chunk sizing for one burst: limits the remaining byte count to what a
// single AXI burst may legally carry and derives the AXI beat count - 1.
module dma_chunk_calc
   import dma_regfile::*;
#(
   parameter int DATA_BYTES = 4,
   parameter int MAX_BEATS  = 16
) (
   input  logic [31:0] remaining,
   input  logic [31:0] src,
   input  logic [31:0] dst,
   input  dma_burst_t  burst,
   output logic [31:0] chunk_bytes,
   output logic [7:0]  cmd_len
);

   localparam logic [31:0] MAX_BYTES = 32'(MAX_BEATS * DATA_BYTES);
   localparam int          SHIFT     = $clog2(DATA_BYTES);

   logic [31:0] src_room;
   logic [31:0] dst_room;
   logic [31:0] beats;

   // Pick the burst size: FIXED caps at the beat limit, INCR also stops at
   // either address's next 4 KB page, WRAP moves everything in one burst.
   always_comb begin
      src_room    = BOUNDARY_4KB - {20'd0, src[11:0]};
      dst_room    = BOUNDARY_4KB - {20'd0, dst[11:0]};
      chunk_bytes = (remaining < MAX_BYTES) ? remaining : MAX_BYTES;
      case (burst)
         BURST_INCR: begin
            if (src_room < chunk_bytes) chunk_bytes = src_room;
            if (dst_room < chunk_bytes) chunk_bytes = dst_room;
         end
         BURST_WRAP: chunk_bytes = remaining;
         default: ;
      endcase
      beats   = chunk_bytes >> SHIFT;
      cmd_len = 8'(beats - 32'd1);
   end

endmodule

// File: rtl/dma_xfer_sched.sv
// DMA transfer sequencer: validates a programmed transfer, splits it into
// AXI-legal bursts and moves each burst store-and-forward (read command,
// read completion, write command, write completion) before the next one.
//
// Command handshakes: *_cmd_valid rises with its payload already set, and
// valid plus payload stay frozen until the clock edge where ready is seen
// high; valid drops right after that edge. Payload holds its last value.
module dma_xfer_sched
   import dma_regfile::*;
#(
   parameter int DATA_BYTES = 4,
   parameter int MAX_BEATS  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      cfg_src,
   input  logic [31:0]      cfg_dst,
   input  logic [31:0]      cfg_len,
   input  logic [1:0]       cfg_burst,
   input  logic             start,
   input  logic             irq_en,
   input  logic             sts_clr,
   output logic             rd_cmd_valid,
   input  logic             rd_cmd_ready,
   output logic [31:0]      rd_cmd_addr,
   output logic [7:0]       rd_cmd_len,
   output logic [1:0]       rd_cmd_burst,
   input  logic             rd_done,
   input  logic             rd_err,
   output logic             wr_cmd_valid,
   input  logic             wr_cmd_ready,
   output logic [31:0]      wr_cmd_addr,
   output logic [7:0]       wr_cmd_len,
   output logic [1:0]       wr_cmd_burst,
   input  logic             wr_done,
   input  logic             wr_err,
   output logic             busy,
   output logic             sts_done,
   output logic             sts_err,
   output logic             irq,
   output dma_sched_state_t dbg_state
);

   localparam logic [31:0] ALIGN_MASK = 32'(DATA_BYTES - 1);
   localparam logic [31:0] WRAP_LEN2  = 32'(2 * DATA_BYTES);
   localparam logic [31:0] WRAP_LEN4  = 32'(4 * DATA_BYTES);
   localparam logic [31:0] WRAP_LEN8  = 32'(8 * DATA_BYTES);
   localparam logic [31:0] WRAP_LEN16 = 32'(16 * DATA_BYTES);

   dma_sched_state_t state;
   logic [31:0]      src;
   logic [31:0]      dst;
   logic [31:0]      remaining;
   logic [31:0]      chunk;
   logic [7:0]       xfer_len;
   dma_burst_t       burst;
   logic             ien;
   logic             first;

   logic [31:0]      calc_chunk;
   logic [7:0]       calc_len;
   logic             wrap_len_ok;
   logic [31:0]      wrap_mask;
   logic             cfg_bad;

   dma_chunk_calc #(
      .DATA_BYTES (DATA_BYTES),
      .MAX_BEATS  (MAX_BEATS)
   ) u_chunk_calc (
      .remaining   (remaining),
      .src         (src),
      .dst         (dst),
      .burst       (burst),
      .chunk_bytes (calc_chunk),
      .cmd_len     (calc_len)
   );

   // Legality of the latched transfer; only consulted for the first chunk.
   always_comb begin
      wrap_len_ok = (remaining == WRAP_LEN2) || (remaining == WRAP_LEN4) ||
                    (remaining == WRAP_LEN8) || (remaining == WRAP_LEN16);
      wrap_mask   = remaining - 32'd1;
      cfg_bad     = (remaining == 32'd0) ||
                    ((src & ALIGN_MASK) != 32'd0) ||
                    ((dst & ALIGN_MASK) != 32'd0) ||
                    ((remaining & ALIGN_MASK) != 32'd0) ||
                    (burst == BURST_ERR) ||
                    ((burst == BURST_WRAP) &&
                     (!wrap_len_ok || ((src & wrap_mask) != 32'd0) ||
                      ((dst & wrap_mask) != 32'd0)));
   end

   // Sequencer FSM with working registers, command outputs and sticky status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         src          <= '0;
         dst          <= '0;
         remaining    <= '0;
         chunk        <= '0;
         xfer_len     <= '0;
         burst        <= BURST_FIXED;
         ien          <= 1'b0;
         first        <= 1'b0;
         rd_cmd_valid <= 1'b0;
         rd_cmd_addr  <= '0;
         rd_cmd_len   <= '0;
         rd_cmd_burst <= '0;
         wr_cmd_valid <= 1'b0;
         wr_cmd_addr  <= '0;
         wr_cmd_len   <= '0;
         wr_cmd_burst <= '0;
         sts_done     <= 1'b0;
         sts_err      <= 1'b0;
      end else begin
         // A clear is overridden by any status set later in this block.
         if (sts_clr) begin
            sts_done <= 1'b0;
            sts_err  <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  src       <= cfg_src;
                  dst       <= cfg_dst;
                  remaining <= cfg_len;
                  burst     <= dma_burst_t'(cfg_burst);
                  ien       <= irq_en;
                  first     <= 1'b1;
                  sts_done  <= 1'b0;
                  sts_err   <= 1'b0;
                  state     <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               first <= 1'b0;
               if (first && cfg_bad) begin
                  sts_err  <= 1'b1;
                  sts_done <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  chunk        <= calc_chunk;
                  xfer_len     <= calc_len;
                  rd_cmd_valid <= 1'b1;
                  rd_cmd_addr  <= src;
                  rd_cmd_len   <= calc_len;
                  rd_cmd_burst <= burst;
                  state        <= ST_RD_CMD;
               end
            end
            ST_RD_CMD: begin
               if (rd_cmd_ready) begin
                  rd_cmd_valid <= 1'b0;
                  state        <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (rd_done) begin
                  if (rd_err) begin
                     sts_err  <= 1'b1;
                     sts_done <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     wr_cmd_valid <= 1'b1;
                     wr_cmd_addr  <= dst;
                     wr_cmd_len   <= xfer_len;
                     wr_cmd_burst <= burst;
                     state        <= ST_WR_CMD;
                  end
               end
            end
            ST_WR_CMD: begin
               if (wr_cmd_ready) begin
                  wr_cmd_valid <= 1'b0;
                  state        <= ST_WR_WAIT;
               end
            end
            ST_WR_WAIT: begin
               if (wr_done) begin
                  if (wr_err) begin
                     sts_err  <= 1'b1;
                     sts_done <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     remaining <= remaining - chunk;
                     if (burst == BURST_INCR) begin
                        src <= src + chunk;
                        dst <= dst + chunk;
                     end
                     if (remaining == chunk) begin
                        sts_done <= 1'b1;
                        sts_err  <= 1'b0;
                        state    <= ST_IDLE;
                     end else begin
                        state <= ST_CHECK;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Status decode straight from registers so reset clears them at once.
   always_comb begin
      busy      = (state != ST_IDLE);
      irq       = ien & (sts_done | sts_err);
      dbg_state = state;
   end

endmodule

// File: tb/tb_dma_xfer_sched.sv
// Bench for dma_xfer_sched: a transfer-level model predicts every burst
// command and the final status; a bus responder plays the AXI engines and a
// monitor compares handshakes and status probes against the queues.
module tb_dma_xfer_sched;
   import dma_regfile::*;

   localparam int DB = 4;
   localparam int MB = 16;
   localparam int CW = 42;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] cfg_src = '0, cfg_dst = '0, cfg_len = '0;
   logic [1:0]  cfg_burst = '0;
   logic        start = 1'b0, irq_en = 1'b0, sts_clr = 1'b0;
   logic        rd_cmd_valid, wr_cmd_valid;
   logic        rd_cmd_ready = 1'b0, wr_cmd_ready = 1'b0;
   logic [31:0] rd_cmd_addr, wr_cmd_addr;
   logic [7:0]  rd_cmd_len, wr_cmd_len;
   logic [1:0]  rd_cmd_burst, wr_cmd_burst;
   logic        rd_done = 1'b0, rd_err = 1'b0, wr_done = 1'b0, wr_err = 1'b0;
   logic        busy, sts_done, sts_err, irq;
   dma_sched_state_t dbg_state;

   // scoreboard queues
   logic [CW-1:0] rd_exp_q[$];
   logic [CW-1:0] wr_exp_q[$];
   string         probe_name_q[$];
   logic [6:0]    probe_exp_q[$];
   logic [6:0]    probe_mask_q[$];

   int checks = 0, passes = 0, fails = 0;
   bit end_req = 1'b0, mon_done = 1'b0;

   // responder controls (written by driver) and counters (written by responder)
   int err_rd_at = -1, err_wr_at = -1;
   bit rd_hold_low = 1'b0, done_hold = 1'b0, spur_en = 1'b0;
   int rd_cnt = 0, wr_cnt = 0;

   dma_xfer_sched #(.DATA_BYTES(DB), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_burst(cfg_burst),
      .start(start), .irq_en(irq_en), .sts_clr(sts_clr),
      .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
      .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len), .rd_cmd_burst(rd_cmd_burst),
      .rd_done(rd_done), .rd_err(rd_err),
      .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
      .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .wr_cmd_burst(wr_cmd_burst),
      .wr_done(wr_done), .wr_err(wr_err),
      .busy(busy), .sts_done(sts_done), .sts_err(sts_err), .irq(irq),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [CW-1:0] pack_cmd(logic [31:0] a, int bytes, logic [1:0] b);
      return {a, 8'(bytes / DB - 1), b};
   endfunction

   function automatic int min2(int a, int b);
      return (a < b) ? a : b;
   endfunction

   // Walks the transfer byte by byte-chunk, queueing the commands the engines
   // should receive; stops at an injected read/write error.
   task automatic model_xfer(input logic [31:0] s_in, input logic [31:0] d_in,
                             input logic [31:0] l, input logic [1:0] b,
                             input int erk, input int ewk,
                             output bit bad, output bit err);
      logic [31:0] s, d;
      int rem, c, k;
      bit wrap_ok;
      s = s_in; d = d_in;
      wrap_ok = (l == 2*DB || l == 4*DB || l == 8*DB || l == 16*DB) &&
                (l != 0) && (s % l == 0) && (d % l == 0);
      bad = (l == 0) || (s % DB != 0) || (d % DB != 0) || (l % DB != 0) ||
            (b == 2'b11) || (b == 2'b10 && !wrap_ok);
      err = bad;
      if (bad) return;
      rem = int'(l);
      k = 0;
      while (rem > 0) begin
         if (b == 2'b10) c = rem;
         else c = min2(rem, MB * DB);
         if (b == 2'b01) begin
            c = min2(c, 4096 - int'(s[11:0]));
            c = min2(c, 4096 - int'(d[11:0]));
         end
         rd_exp_q.push_back(pack_cmd(s, c, b));
         if (k == erk) begin err = 1'b1; return; end
         wr_exp_q.push_back(pack_cmd(d, c, b));
         if (k == ewk) begin err = 1'b1; return; end
         rem = rem - c;
         if (b == 2'b01) begin s = s + 32'(c); d = d + 32'(c); end
         k++;
      end
   endtask

   // ---------------- bus responder ----------------
   int rd_wait = -1, wr_wait = -1;
   bit rd_v_prev = 1'b0, rd_r_prev = 1'b0, wr_v_prev = 1'b0, wr_r_prev = 1'b0;

   always @(posedge clk) begin
      #1;
      rd_done = 1'b0; rd_err = 1'b0; wr_done = 1'b0; wr_err = 1'b0;
      if (!rst_n) begin
         rd_wait = -1; wr_wait = -1;
         rd_v_prev = 1'b0; rd_r_prev = 1'b0; wr_v_prev = 1'b0; wr_r_prev = 1'b0;
         rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0;
      end else begin
         if (rd_v_prev && rd_r_prev) rd_wait = int'($urandom_range(0, 3));
         if (wr_v_prev && wr_r_prev) wr_wait = int'($urandom_range(0, 3));
         if (!done_hold) begin
            if (rd_wait == 0) begin
               rd_done = 1'b1; rd_err = (rd_cnt == err_rd_at); rd_cnt++; rd_wait = -1;
            end else if (rd_wait > 0) rd_wait--;
            if (wr_wait == 0) begin
               wr_done = 1'b1; wr_err = (wr_cnt == err_wr_at); wr_cnt++; wr_wait = -1;
            end else if (wr_wait > 0) wr_wait--;
         end
         if (spur_en) begin rd_done = 1'b1; wr_done = 1'b1; end
         rd_cmd_ready = rd_hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
         wr_cmd_ready = ($urandom_range(0, 2) != 0);
         rd_v_prev = rd_cmd_valid; rd_r_prev = rd_cmd_ready;
         wr_v_prev = wr_cmd_valid; wr_r_prev = wr_cmd_ready;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic check(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] obs();
      logic nz;
      nz = |{rd_cmd_addr, rd_cmd_len, rd_cmd_burst, wr_cmd_addr, wr_cmd_len, wr_cmd_burst};
      return {nz, busy, sts_done, sts_err, irq, rd_cmd_valid, wr_cmd_valid};
   endfunction

   bit            rd_pend = 1'b0, wr_pend = 1'b0;
   logic [CW-1:0] rd_hold_pl, wr_hold_pl;

   always @(negedge clk) begin
      logic [CW-1:0] rd_pl, wr_pl, e;
      logic [6:0] pm, pe;
      string pn;
      rd_pl = {rd_cmd_addr, rd_cmd_len, rd_cmd_burst};
      wr_pl = {wr_cmd_addr, wr_cmd_len, wr_cmd_burst};
      if (!rst_n) begin
         rd_pend = 1'b0; wr_pend = 1'b0;
      end else begin
         if (rd_pend) check("rd_stable", {rd_cmd_valid, rd_pl}, {1'b1, rd_hold_pl});
         if (wr_pend) check("wr_stable", {wr_cmd_valid, wr_pl}, {1'b1, wr_hold_pl});
         rd_pend = 1'b0; wr_pend = 1'b0;
         if (rd_cmd_valid && rd_cmd_ready) begin
            if (rd_exp_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL rd_extra: got cmd %0h expected none (t=%0t)", rd_pl, $time);
            end else begin
               e = rd_exp_q.pop_front();
               check("rd_cmd", rd_pl, e);
            end
         end else if (rd_cmd_valid) begin
            rd_pend = 1'b1; rd_hold_pl = rd_pl;
         end
         if (wr_cmd_valid && wr_cmd_ready) begin
            if (wr_exp_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL wr_extra: got cmd %0h expected none (t=%0t)", wr_pl, $time);
            end else begin
               e = wr_exp_q.pop_front();
               check("wr_cmd", wr_pl, e);
            end
         end else if (wr_cmd_valid) begin
            wr_pend = 1'b1; wr_hold_pl = wr_pl;
         end
      end
      if (probe_name_q.size() > 0) begin
         pn = probe_name_q.pop_front();
         pe = probe_exp_q.pop_front();
         pm = probe_mask_q.pop_front();
         check(pn, 64'(obs() & pm), 64'(pe & pm));
      end
      if (end_req && !mon_done) begin
         check("rd_leftover", 64'(rd_exp_q.size()), 64'd0);
         check("wr_leftover", 64'(wr_exp_q.size()), 64'd0);
         mon_done = 1'b1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observed vector order: {payload_nz, busy, done, err, irq, rd_v, wr_v}
   task automatic probe(string n, logic [6:0] e, logic [6:0] m);
      probe_name_q.push_back(n);
      probe_exp_q.push_back(e);
      probe_mask_q.push_back(m);
   endtask

   task automatic wait_idle(int max);
      tick();
      for (int i = 0; i < max && busy; i++) tick();
   endtask

   task automatic clear_sts();
      sts_clr = 1'b1;
      tick();
      sts_clr = 1'b0;
      probe("sts_clr", 7'b0000000, 7'b0111111);
   endtask

   task automatic run_xfer(logic [31:0] s, logic [31:0] d, logic [31:0] l,
                           logic [1:0] b, logic ien, int erk, int ewk, bit busy_start);
      bit bad, err;
      model_xfer(s, d, l, b, erk, ewk, bad, err);
      err_rd_at = (erk < 0) ? -1 : rd_cnt + erk;
      err_wr_at = (ewk < 0) ? -1 : wr_cnt + ewk;
      cfg_src = s; cfg_dst = d; cfg_len = l; cfg_burst = b; irq_en = ien;
      start = 1'b1;
      tick();
      start = 1'b0;
      probe("start_busy", 7'b0100000, 7'b0111111);
      tick();
      if (bad) probe("start_err", {3'b000, 1'b1, ien, 2'b00}, 7'b0111111);
      else     probe("start_rdv", 7'b0100010, 7'b0111111);
      if (busy_start) begin
         tick();
         cfg_src = 32'hDEAD_0000; cfg_dst = 32'h0000_0010; cfg_len = 32'd4;
         cfg_burst = 2'b00; irq_en = ~ien;
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      wait_idle(3000);
      probe("xfer_end", {2'b00, ~err, err, ien, 2'b00}, 7'b0111111);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] s, d, l;
      logic [1:0]  b;
      int sel, erk, ewk;

      repeat (3) @(posedge clk);
      #1;
      probe("reset_state", 7'b0000000, 7'b1111111);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      run_xfer(32'h1000, 32'h2000, 32'd64, 2'b01, 1'b1, -1, -1, 1'b0);
      clear_sts();
      run_xfer(32'h0FF8, 32'h3000, 32'd32, 2'b01, 1'b0, -1, -1, 1'b0);
      run_xfer(32'h1002, 32'h2000, 32'd64, 2'b01, 1'b1, -1, -1, 1'b0);
      run_xfer(32'h1000, 32'h2000, 32'd64, 2'b11, 1'b1, -1, -1, 1'b0);
      run_xfer(32'h1000, 32'h2000, 32'd0,  2'b01, 1'b0, -1, -1, 1'b0);
      run_xfer(32'h1000, 32'h2000, 32'd128, 2'b01, 1'b1, 1, -1, 1'b1);
      clear_sts();
      run_xfer(32'h4000, 32'h5000, 32'd96, 2'b00, 1'b0, -1, -1, 1'b0);
      run_xfer(32'h0100, 32'h0220, 32'd32, 2'b10, 1'b1, -1, -1, 1'b0);
      run_xfer(32'h1000, 32'h2000, 32'd128, 2'b01, 1'b0, -1, 0, 1'b0);

      // completions while idle must leave status untouched (err=1, ien=0)
      spur_en = 1'b1;
      repeat (3) tick();
      spur_en = 1'b0;
      tick();
      probe("spurious_done", 7'b0001000, 7'b0111111);
      tick();

      // read command stalled, then reset while waiting for read data
      err_rd_at = -1; err_wr_at = -1;
      rd_exp_q.push_back(pack_cmd(32'h6000, 64, 2'b01));
      rd_hold_low = 1'b1; done_hold = 1'b1;
      cfg_src = 32'h6000; cfg_dst = 32'h7000; cfg_len = 32'd64; cfg_burst = 2'b01; irq_en = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10 && !rd_cmd_valid; i++) tick();
      repeat (5) tick();
      rd_hold_low = 1'b0;
      for (int i = 0; i < 40 && rd_cmd_valid; i++) tick();
      tick();
      @(posedge clk);
      #3 rst_n = 1'b0;
      probe("async_reset", 7'b0000000, 7'b1111111);
      @(posedge clk);
      #3 rst_n = 1'b1;
      done_hold = 1'b0;
      repeat (8) tick();
      probe("no_reissue", 7'b0000000, 7'b1111111);
      tick();
      run_xfer(32'h8000, 32'h9000, 32'd64, 2'b01, 1'b1, -1, -1, 1'b0);

      // randomized transfers
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 9));
         erk = -1; ewk = -1;
         if (sel <= 6) begin
            b = (sel <= 4) ? 2'b01 : 2'b00;
            s = ($urandom_range(0, 255) << 12) | ((32'd4096 - 32'(4 * $urandom_range(0, 48))) & 32'hFFF);
            d = ($urandom_range(0, 255) << 12) | ((32'd4096 - 32'(4 * $urandom_range(0, 48))) & 32'hFFF);
            l = 32'(4 * $urandom_range(1, 64));
            if ($urandom_range(0, 9) == 0) s = s + 32'd2;
         end else if (sel <= 8) begin
            b = 2'b10;
            l = 32'(DB << $urandom_range(1, 4));
            s = 32'(64 * $urandom_range(0, 1023));
            d = 32'(64 * $urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) l = 32'd12;
            if ($urandom_range(0, 7) == 0) d = d + 32'd4;
         end else begin
            b = 2'b11;
            s = 32'h100; d = 32'h200; l = 32'd16;
         end
         if ($urandom_range(0, 7) == 0) erk = int'($urandom_range(0, 1));
         else if ($urandom_range(0, 7) == 0) ewk = int'($urandom_range(0, 1));
         run_xfer(s, d, l, b, logic'($urandom_range(0, 1)), erk, ewk, 1'b0);
         if ($urandom_range(0, 3) == 0) clear_sts();
      end

      tick();
      end_req = 1'b1;
      for (int i = 0; i < 5 && !mon_done; i++) tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
